// File: rtl/adder_pkg.sv
// adder_pkg: definitions shared by the serial adder slice.
//   state_t   - controller state encoding (IDLE/RUN/DONE)
//   MAX_WIDTH - largest supported operand width
package adder_pkg;

    localparam int unsigned MAX_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_cell.sv
// fa_cell: 1-bit full adder made from two half adders plus an OR for carry.
// Purely combinational.
//   s  - sum bit x ^ y ^ ci
//   co - carry out, majority(x, y, ci)
//   x  - operand bit
//   y  - operand bit
//   ci - carry in
module fa_cell (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y,
    input  logic ci
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .s  (s0),
        .co (c0),
        .x  (x),
        .y  (y)
    );

    half_adder u_ha1 (
        .s  (s),
        .co (c1),
        .x  (s0),
        .y  (ci)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign co = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// half_adder: 1-bit half adder, purely combinational.
//   s  - sum bit (x ^ y)
//   co - carry bit (x & y)
//   x  - input bit
//   y  - input bit
module half_adder (
    output logic s,
    output logic co,
    input  logic x,
    input  logic y
);

    assign s  = x ^ y;
    assign co = x & y;

endmodule

// File: rtl/serial_add_seq.sv
// serial_add_seq: bit-serial WIDTH-bit adder sharing one fa_cell, LSB first.
//   clk   - rising-edge clock
//   rst   - synchronous active-high reset
//   start - begin an add; accepted in IDLE or DONE
//   a, b  - operands, sampled only in the accepting cycle
//   busy  - high while the add runs (RUN state)
//   done  - one-cycle pulse when sum/cout are updated
//   sum   - registered result a+b mod 2^WIDTH, held until the next done
//   cout  - registered carry out of bit WIDTH-1
module serial_add_seq
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned      CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH - 1);

    if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_width_check
        $error("serial_add_seq: WIDTH out of range");
    end

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] sa;
    logic [WIDTH-1:0] sb;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH:0]   r_ext;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             c;
    logic [CNT_W-1:0] cnt;
    logic             s;
    logic             co;
    logic             accept;

    fa_cell u_fa (
        .s  (s),
        .co (co),
        .x  (sa[0]),
        .y  (sb[0]),
        .ci (c)
    );

    always_comb begin
        accept  = start && (state == ST_IDLE || state == ST_DONE);
        // New bit enters at the MSB; the extra bit keeps WIDTH=1 legal.
        r_ext   = {s, r};
        r_n     = r_ext[WIDTH:1];
        state_n = state;
        unique case (state)
            ST_IDLE: if (start) state_n = ST_RUN;
            ST_RUN:  if (cnt == LAST) state_n = ST_DONE;
            ST_DONE: state_n = start ? ST_RUN : ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sa     <= '0;
            sb     <= '0;
            r      <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else if (accept) begin
            sa  <= a;
            sb  <= b;
            c   <= 1'b0;
            cnt <= '0;
        end else if (state == ST_RUN) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            r   <= r_n;
            c   <= co;
            cnt <= cnt + CNT_W'(1);
            if (cnt == LAST) begin
                sum_q  <= r_n;
                cout_q <= co;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
module tb_serial_add_seq;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;

    logic        st8, st1, st13;
    logic [7:0]  a8, b8;
    logic        a1, b1;
    logic [12:0] a13, b13;

    logic        bz8, dn8, co8;
    logic [7:0]  sm8;
    logic        bz1, dn1, co1;
    logic        sm1;
    logic        bz13, dn13, co13;
    logic [12:0] sm13;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        int          due;
    } exp_t;

    exp_t        q[3][$];
    int unsigned wid[3] = '{8, 1, 13};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_add_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(st8), .a(a8), .b(b8),
        .busy(bz8), .done(dn8), .sum(sm8), .cout(co8)
    );
    serial_add_seq #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(st1), .a(a1), .b(b1),
        .busy(bz1), .done(dn1), .sum(sm1), .cout(co1)
    );
    serial_add_seq #(.WIDTH(13)) dut13 (
        .clk(clk), .rst(rst), .start(st13), .a(a13), .b(b13),
        .busy(bz13), .done(dn13), .sum(sm13), .cout(co13)
    );

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer addition of the width-truncated operands.
    task automatic issue(input int id, input logic [31:0] x, input logic [31:0] y, input bit hold);
        longint unsigned mask, tot;
        exp_t e;
        mask   = (64'd1 << wid[id]) - 1;
        tot    = (longint'(x) & mask) + (longint'(y) & mask);
        e.sum  = 32'(tot & mask);
        e.cout = ((tot >> wid[id]) & 64'd1) != 0;
        e.due  = cyc + int'(wid[id]) + 1;
        case (id)
            0: begin st8 = 1'b1;  a8 = x[7:0];   b8 = y[7:0];   end
            1: begin st1 = 1'b1;  a1 = x[0];     b1 = y[0];     end
            default: begin st13 = 1'b1; a13 = x[12:0]; b13 = y[12:0]; end
        endcase
        q[id].push_back(e);
        tick();
        if (!hold) begin
            case (id)
                0: st8 = 1'b0;
                1: st1 = 1'b0;
                default: st13 = 1'b0;
            endcase
        end
    endtask

    task automatic mon(input int id, input logic dn, input logic [31:0] s, input logic co);
        exp_t e;
        if (dn === 1'b1) begin
            if (q[id].size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done dut%0d: got done=1 expected done=0 at cycle %0d", id, cyc);
            end else begin
                e = q[id].pop_front();
                check($sformatf("sum dut%0d", id), 64'(s), 64'(e.sum));
                check($sformatf("cout dut%0d", id), 64'(co), 64'(e.cout));
                check($sformatf("done_cycle dut%0d", id), 64'(cyc), 64'(e.due));
            end
        end else if (q[id].size() != 0 && cyc > q[id][0].due) begin
            checks++;
            failures++;
            $display("FAIL missing_done dut%0d: got no done expected done at cycle %0d", id, q[id][0].due);
            void'(q[id].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            mon(0, dn8, 32'(sm8), co8);
            mon(1, dn1, 32'(sm1), co1);
            mon(2, dn13, 32'(sm13), co13);
        end
    end

    task automatic drain();
        int n = 0;
        while ((q[0].size() + q[1].size() + q[2].size()) != 0 && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if ((q[0].size() + q[1].size() + q[2].size()) != 0) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q[0].size() + q[1].size() + q[2].size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish by 2000000");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        st8 = 1'b0; st1 = 1'b0; st13 = 1'b0;
        a8 = '0; b8 = '0; a1 = 1'b0; b1 = 1'b0; a13 = '0; b13 = '0;
        repeat (3) tick();
        @(negedge clk);
        check("rst busy8", 64'(bz8), 0);  check("rst done8", 64'(dn8), 0);
        check("rst sum8", 64'(sm8), 0);   check("rst cout8", 64'(co8), 0);
        check("rst busy1", 64'(bz1), 0);  check("rst done1", 64'(dn1), 0);
        check("rst busy13", 64'(bz13), 0); check("rst sum13", 64'(sm13), 0);
        tick();
        rst = 1'b0;
        tick();

        // 0x0F + 0x01 with busy/done profile over cycles 1..9
        issue(0, 32'h0F, 32'h01, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check($sformatf("busy8 c%0d", k), 64'(bz8), 1);
            check($sformatf("done8 c%0d", k), 64'(dn8), 0);
            tick();
        end
        @(negedge clk);
        check("busy8 c9", 64'(bz8), 0);
        check("done8 c9", 64'(dn8), 1);
        tick();
        drain();

        issue(0, 32'hFF, 32'h01, 1'b0); drain();
        issue(0, 32'h00, 32'h00, 1'b0); drain();
        issue(0, 32'hFF, 32'hFF, 1'b0); drain();

        // start during RUN is ignored; outputs hold 0xFE/1 until done
        issue(0, 32'h12, 32'h34, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            if (k == 4) begin st8 = 1'b1; a8 = 8'hAA; end
            @(negedge clk);
            check($sformatf("ign busy8 c%0d", k), 64'(bz8), 1);
            check($sformatf("ign sum8 c%0d", k), 64'(sm8), 64'hFE);
            check($sformatf("ign cout8 c%0d", k), 64'(co8), 1);
            tick();
            if (k == 4) st8 = 1'b0;
        end
        drain();

        // start held high: 0x01+0x01 then 0x80+0x80 accepted in DONE
        issue(0, 32'h01, 32'h01, 1'b1);
        a8 = 8'h80; b8 = 8'h80;
        repeat (8) tick();
        issue(0, 32'h80, 32'h80, 1'b0);
        drain();

        // reset mid-add abandons it
        issue(0, 32'h55, 32'h55, 1'b0);
        repeat (4) tick();
        rst = 1'b1;
        void'(q[0].pop_back());
        tick();
        @(negedge clk);
        check("midrst busy8", 64'(bz8), 0);
        check("midrst done8", 64'(dn8), 0);
        check("midrst sum8", 64'(sm8), 0);
        check("midrst cout8", 64'(co8), 0);
        tick();
        rst = 1'b0;
        repeat (12) tick();
        issue(0, 32'h55, 32'h55, 1'b0);
        drain();

        // WIDTH=1, including back-to-back starts
        issue(1, 32'h1, 32'h1, 1'b0);
        tick();
        issue(1, 32'h1, 32'h0, 1'b0);
        tick();
        issue(1, 32'h0, 32'h0, 1'b0);
        drain();

        // randomized WIDTH=13, with random back-to-back or idle gaps
        for (int n = 0; n < 1000; n++) begin
            issue(2, $urandom, $urandom, 1'b0);
            repeat (13) tick();
            repeat ($urandom_range(0, 2)) tick();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_add_seq.md
# serial_add_seq

Bit-serial addition controller that time-shares a single 1-bit full-adder cell, built from two `half_adder` instances, across a WIDTH-bit add. It latches two operands on a start handshake and feeds the cell one bit per cycle, LSB first, with a registered carry between bits. When finished it presents the registered sum and carry-out with a one-cycle done pulse. It trades latency for area for arithmetic blocks in the same design that cannot afford a parallel adder.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 1..32
- clk  input  1  rising-edge clock, the only clock
- rst  input  1  reset, synchronous and active-high
- start  input  1  request to begin an add; sampled on clk
- a  input  WIDTH  operand A; sampled only in the cycle start is accepted
- b  input  WIDTH  operand B; sampled only in the cycle start is accepted
- busy  output  1  high while the add is in progress (RUN state)
- done  output  1  one-cycle pulse; sum and cout are valid from this cycle on
- sum  output  WIDTH  registered result, a+b mod 2^WIDTH
- cout  output  1  registered carry out of bit WIDTH-1

## Operation
- States:
  - IDLE (reset state)
  - RUN
  - DONE
- IDLE, start=1:
  - Load a and b into shift registers sa and sb.
  - Clear the carry register c and the bit counter cnt, which is $clog2(WIDTH+1) bits wide.
  - Next state RUN.
- IDLE, start=0: stay in IDLE.
- RUN, every cycle:
  - The cell computes s = sa[0]^sb[0]^c and co = majority(sa[0], sb[0], c).
  - Shift sa and sb right by one.
  - Shift s into the MSB of the result shift register r, moving the rest of r right.
  - c <= co; cnt <= cnt+1.
- RUN, cnt == WIDTH-1: after that cycle's update, load sum <= the final r, load cout <= co, and go to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - start=1 in this cycle is accepted exactly as in IDLE and goes to RUN.
  - Otherwise go to IDLE.
- start while in RUN is ignored. Operands are not re-sampled and no error is flagged.
- sum and cout hold their last result until the next DONE overwrites them. They do not change during RUN.
- Reset:
  - rst=1 at any clock edge forces IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - sa, sb, r, c and cnt are all cleared.
  - Reset takes priority over start.
  - Reset in the middle of an add abandons it, and no done is produced for it.
- Width rules:
  - No overflow flag. cout is the unsigned carry.
  - The operation is the same for signed operands; interpreting the result as signed is the caller's job.

## Timing
- Start is accepted in cycle 0, meaning high at the end of cycle 0.
- busy=1 in cycles 1..WIDTH.
- done=1 and busy=0 in cycle WIDTH+1. sum and cout are valid from cycle WIDTH+1.
- Latency is WIDTH+1 cycles from start to done.
- Back-to-back throughput: a start held high through DONE gives one result every WIDTH+1 cycles.
- WIDTH=1: a single RUN cycle, with done in cycle 2.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package (`adder_pkg`): state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2, plus the maximum-WIDTH constant 32.
- Sub-module `fa_cell`: one full adder built from two `half_adder` instances and an OR gate for the carry, with ports (s, co, x, y, ci). It is purely combinational and is instanced once.
- The top level holds the FSM, counter, shift registers, carry register and output registers.

## Test plan
- WIDTH=8, a=0x0F, b=0x01, start pulse -> busy for cycles 1..8, done in cycle 9, sum=0x10, cout=0.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1; then a=0xFF, b=0xFF -> sum=0xFE, cout=1; a=0, b=0 -> sum=0x00, cout=0.
- WIDTH=8, add 0x12+0x34, then pulse start with a=0xAA in cycle 4 -> the pulse is ignored, done in cycle 9 with sum=0x46, and sum/cout stay unchanged through cycles 1..8.
- Start held high with 0x01+0x01 and then 0x80+0x80 -> done in cycles 9 and 18, with sum=0x02 cout=0 and then sum=0x00 cout=1.
- Start 0x55+0x55, assert rst in cycle 5 -> cycle 6 is IDLE with busy=0, done=0, sum=0, cout=0; no done for that add; a new start then completes normally.
- WIDTH=1: a=1, b=1 -> done in cycle 2, sum=0, cout=1. A randomized run of 1000 adds at WIDTH=13 is checked against a behavioural a+b model.
